sw_event_counter: RTL and testbench
===================================

# sw_event_counter

Multi-channel switch front end: synchronises `CH` raw switch/contact inputs to `CLK`, debounces each one with a programmable stability filter, detects edges of the selected polarity, and counts events per channel in a modulo-`CNT_MOD` counter with a wrap carry. It sits between panel/board switch inputs and the control logic that consumes debounced levels, edge strobes and event counts. The `CARRY` outputs can chain further digits.

## Interface

- `CH`, 4: number of independent switch channels.
- `DB_CYCLES`, 4: consecutive synchronised samples that must differ from the debounced level before it flips. Must be ≥1.
- `CNT_MOD`, 10: event counter modulus. Must satisfy 2 ≤ `CNT_MOD` ≤ 2^`CNT_W`.
- `CNT_W`, 4: event counter width per channel.

- `CLK`, in, 1: clock, rising edge.
- `RESET_B`, in, 1: reset RESET_B, asynchronous, active-low; clock CLK.
- `SW_IN`, in, `CH`: raw asynchronous switch inputs.
- `MODE`, in, 2: global edge select. 00 = counting disabled, 01 = rising, 10 = falling, 11 = both.
- `CLR`, in, 1: synchronous clear of all event counters.
- `SW_STATE`, out, `CH`: debounced level per channel.
- `EDGE`, out, `CH`: one-cycle strobe per channel on a debounced transition matching `MODE`.
- `Q`, out, `CH*CNT_W`: event counts. Channel i occupies bits [i*CNT_W +: CNT_W].
- `CARRY`, out, `CH`: one-cycle strobe when channel i wraps from `CNT_MOD`-1 to 0.

## Operation

- Per channel, a 2-flop synchroniser `s1` → `s2`. Only `s2` is used downstream.
- Per-channel debounce counter `dbc`, width clog2(`DB_CYCLES`), minimum 1 bit. It is evaluated at every edge:
  - `s2` == `SW_STATE[i]`: `dbc` <= 0.
  - `s2` != `SW_STATE[i]` and `dbc` == `DB_CYCLES`-1: `SW_STATE[i]` <= `s2`, `dbc` <= 0, flip asserted.
  - Otherwise: `dbc` <= `dbc`+1.
- Edge qualification uses the flip direction:
  - rise = flip with new level 1; fall = flip with new level 0.
  - ev[i] = (`MODE[0]` & rise) | (`MODE[1]` & fall).
- Registered outputs are updated on the flip edge, so they are visible in the same cycle as the new `SW_STATE`:
  - `EDGE[i]` <= ev[i].
  - When ev[i] is set and `CLR` is low: `Q`[i] <= (`Q`[i] == `CNT_MOD`-1) ? 0 : `Q`[i]+1.
  - `CARRY[i]` <= ev[i] & ~`CLR` & (`Q`[i] == `CNT_MOD`-1).
- `CLR` sets all `Q` to 0 at the next edge and takes priority over any coincident event.
  - The coincident event is not counted and `CARRY` stays 0.
  - `EDGE` is still reported.
- `MODE` = 00: `SW_STATE` keeps tracking, while `EDGE` and `CARRY` stay 0 and `Q` holds.
- A `MODE` change takes effect on the next edge evaluation. There is no retroactive counting.
- Channels are fully independent. Simultaneous events on several channels are each counted in the same cycle.

## Timing

- Reset (asynchronous, `RESET_B`=0): `s1`, `s2`, `dbc`, `SW_STATE`, `EDGE`, `CARRY` and `Q` all go to 0 immediately.
- Reset mid-debounce discards the partial count.
- A channel held high through reset release is seen as a debounced rise `DB_CYCLES`+2 edges later and is counted if `MODE[0]`=1. This is intentional.
- Latency: `SW_IN` changes and is stable from before edge n.
  - `s1` updates at edge n, `s2` at edge n+1.
  - `SW_STATE`, `EDGE`, `Q` and `CARRY` update at edge n+1+`DB_CYCLES`.
  - Total: `DB_CYCLES`+2 edges after the first sampling edge.
- Glitch rejection:
  - A level present in `s2` for fewer than `DB_CYCLES` consecutive samples never changes `SW_STATE`.
  - Exactly `DB_CYCLES` samples is accepted.
- `DB_CYCLES`=1: `SW_STATE` follows `s2` with one cycle delay.
- `EDGE` and `CARRY` are high for exactly one cycle per event. A new event on the same channel needs at least `DB_CYCLES` further samples.
- Wrap: `Q` goes `CNT_MOD`-1 → 0 with `CARRY` high in that same cycle. `Q` never holds a value ≥ `CNT_MOD`.

## Test plan

- Latency. Defaults, `MODE`=01: raise `SW_IN[0]` before edge 10 and hold. `SW_STATE[0]`, `EDGE[0]` (one cycle) and `Q[3:0]`=1 must appear after edge 15. Other channels stay 0.
- Glitch. Pulse `SW_IN[1]` high for 3 cycles, then repeat with 4 cycles. The 3-cycle pulse leaves `SW_STATE[1]`=0 and `Q`=0. The 4-cycle pulse gives `SW_STATE[1]`=1 and `Q`[1]=1.
- Modes. Apply 3 full toggles on channel 2 under `MODE`=01, 10, 11 and 00. `Q`[2] must read 3, 3, 6 and 0 respectively (`CLR` between runs).
- Wrap and carry. Apply 10 debounced rises on channel 3. `Q`[3] reads 9 after the 9th rise. The 10th gives `Q`[3]=0 with `CARRY[3]`=1 for exactly one cycle.
- `CLR` collision. With `Q`[0]=9, assert `CLR` in the cycle of the 10th rise. Required: `Q`[0]=0, `CARRY[0]`=0, `EDGE[0]`=1. The next rise gives `Q`[0]=1.
- Reset. Drop `RESET_B` mid-debounce with `Q`[0]=5. All outputs read 0 immediately. With `SW_IN[0]` still high at release, `Q`[0]=1 after `DB_CYCLES`+2 edges.

Source files
------------

// File: rtl/sw_event_counter.sv
// Multi-channel switch front end: two-flop synchroniser, per-channel debounce filter,
// polarity-selected edge detection and a modulo event counter with wrap carry per channel.
module sw_event_counter #(
    parameter int unsigned CH        = 4,
    parameter int unsigned DB_CYCLES = 4,
    parameter int unsigned CNT_MOD   = 10,
    parameter int unsigned CNT_W     = 4
) (
    input  logic                CLK,
    input  logic                RESET_B,
    input  logic [CH-1:0]       SW_IN,
    input  logic [1:0]          MODE,
    input  logic                CLR,
    output logic [CH-1:0]       SW_STATE,
    output logic [CH-1:0]       EDGE,
    output logic [CH*CNT_W-1:0] Q,
    output logic [CH-1:0]       CARRY
);

    localparam int unsigned      DBC_W    = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [DBC_W-1:0] DBC_LAST = DBC_W'(DB_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MOD - 1);

    logic [CH-1:0]    s1_q, s2_q;
    logic [CH-1:0]    sw_state_q, sw_state_d;
    logic [CH-1:0]    edge_q, edge_d;
    logic [CH-1:0]    carry_q, carry_d;
    logic [DBC_W-1:0] dbc_q [CH];
    logic [DBC_W-1:0] dbc_d [CH];
    logic [CNT_W-1:0] cnt_q [CH];
    logic [CNT_W-1:0] cnt_d [CH];

    // Two-flop synchroniser for the asynchronous switch inputs
    always_ff @(posedge CLK or negedge RESET_B) begin
        if (!RESET_B) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= SW_IN;
            s2_q <= s1_q;
        end
    end

    // Debounce, edge qualification and counter next-state per channel
    always_comb begin : next_state
        logic flip;
        logic ev;
        logic wrap;
        sw_state_d = sw_state_q;
        edge_d     = '0;
        carry_d    = '0;
        for (int i = 0; i < CH; i++) begin
            flip     = 1'b0;
            dbc_d[i] = dbc_q[i];
            cnt_d[i] = cnt_q[i];
            if (s2_q[i] == sw_state_q[i]) begin
                dbc_d[i] = '0;
            end else if (dbc_q[i] == DBC_LAST) begin
                sw_state_d[i] = s2_q[i];
                dbc_d[i]      = '0;
                flip          = 1'b1;
            end else begin
                dbc_d[i] = dbc_q[i] + 1'b1;
            end
            // New level after a flip is s2, so its value gives the direction
            ev         = flip & ((MODE[0] & s2_q[i]) | (MODE[1] & ~s2_q[i]));
            wrap       = (cnt_q[i] == CNT_LAST);
            edge_d[i]  = ev;
            carry_d[i] = ev & ~CLR & wrap;
            // Clear wins over a coincident event, which is then dropped
            if (CLR) begin
                cnt_d[i] = '0;
            end else if (ev) begin
                cnt_d[i] = wrap ? '0 : cnt_q[i] + 1'b1;
            end
        end
    end

    // State and registered outputs
    always_ff @(posedge CLK or negedge RESET_B) begin
        if (!RESET_B) begin
            sw_state_q <= '0;
            edge_q     <= '0;
            carry_q    <= '0;
            for (int i = 0; i < CH; i++) begin
                dbc_q[i] <= '0;
                cnt_q[i] <= '0;
            end
        end else begin
            sw_state_q <= sw_state_d;
            edge_q     <= edge_d;
            carry_q    <= carry_d;
            for (int i = 0; i < CH; i++) begin
                dbc_q[i] <= dbc_d[i];
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // Pack per-channel counts onto the flat output bus
    always_comb begin
        Q = '0;
        for (int i = 0; i < CH; i++) begin
            Q[i*CNT_W +: CNT_W] = cnt_q[i];
        end
    end

    assign SW_STATE = sw_state_q;
    assign EDGE     = edge_q;
    assign CARRY    = carry_q;

endmodule

// File: tb/tb_sw_event_counter.sv
// Directed self-checking bench for sw_event_counter with default parameters.
module tb_sw_event_counter;

    logic        CLK = 1'b0;
    logic        RESET_B;
    logic [3:0]  SW_IN;
    logic [1:0]  MODE;
    logic        CLR;
    logic [3:0]  SW_STATE;
    logic [3:0]  EDGE;
    logic [15:0] Q;
    logic [3:0]  CARRY;

    int checks   = 0;
    int failures = 0;

    sw_event_counter #(
        .CH        (4),
        .DB_CYCLES (4),
        .CNT_MOD   (10),
        .CNT_W     (4)
    ) dut (
        .CLK      (CLK),
        .RESET_B  (RESET_B),
        .SW_IN    (SW_IN),
        .MODE     (MODE),
        .CLR      (CLR),
        .SW_STATE (SW_STATE),
        .EDGE     (EDGE),
        .Q        (Q),
        .CARRY    (CARRY)
    );

    always #5 CLK = ~CLK;

    // Advance n rising edges; inputs are driven and outputs sampled 1 ns after the edge
    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge CLK);
            #1;
        end
    endtask

    function automatic logic [3:0] qch(input int ch);
        return Q[ch*4 +: 4];
    endfunction

    task automatic pulse_clr();
        CLR = 1'b1;
        tick(1);
        CLR = 1'b0;
    endtask

    // One full debounced high/low cycle on a channel
    task automatic toggle(input int ch);
        SW_IN[ch] = 1'b1;
        tick(8);
        SW_IN[ch] = 1'b0;
        tick(8);
    endtask

    task automatic test_reset();
        RESET_B = 1'b0;
        SW_IN   = '0;
        MODE    = 2'b01;
        CLR     = 1'b0;
        #1;
        checks++;
        if ({SW_STATE, EDGE, CARRY, Q} !== 28'h0) begin
            failures++;
            $display("FAIL reset_outputs: got %h want 0", {SW_STATE, EDGE, CARRY, Q});
        end
        tick(2);
        RESET_B = 1'b1;
        tick(2);
    endtask

    task automatic test_latency();
        SW_IN[0] = 1'b1;
        tick(5);
        checks++;
        if (SW_STATE !== 4'b0000 || Q !== 16'h0000) begin
            failures++;
            $display("FAIL latency_early: state=%b q=%h want 0000/0000", SW_STATE, Q);
        end
        tick(1);
        checks++;
        if (SW_STATE !== 4'b0001 || EDGE !== 4'b0001 || Q !== 16'h0001 || CARRY !== 4'b0000) begin
            failures++;
            $display("FAIL latency_flip: state=%b edge=%b q=%h carry=%b want 0001/0001/0001/0000",
                     SW_STATE, EDGE, Q, CARRY);
        end
        tick(1);
        checks++;
        if (EDGE !== 4'b0000 || Q !== 16'h0001) begin
            failures++;
            $display("FAIL latency_edge_once: edge=%b q=%h want 0000/0001", EDGE, Q);
        end
    endtask

    task automatic test_glitch();
        SW_IN[1] = 1'b1;
        tick(3);
        SW_IN[1] = 1'b0;
        tick(10);
        checks++;
        if (SW_STATE[1] !== 1'b0 || qch(1) !== 4'd0) begin
            failures++;
            $display("FAIL glitch_3: state1=%b q1=%0d want 0/0", SW_STATE[1], qch(1));
        end
        SW_IN[1] = 1'b1;
        tick(4);
        SW_IN[1] = 1'b0;
        tick(2);
        checks++;
        if (SW_STATE[1] !== 1'b1 || qch(1) !== 4'd1 || EDGE !== 4'b0010) begin
            failures++;
            $display("FAIL glitch_4: state1=%b q1=%0d edge=%b want 1/1/0010",
                     SW_STATE[1], qch(1), EDGE);
        end
        tick(10);
    endtask

    task automatic test_modes();
        logic [1:0] modes [4];
        logic [3:0] expq  [4];
        modes = '{2'b01, 2'b10, 2'b11, 2'b00};
        expq  = '{4'd3, 4'd3, 4'd6, 4'd0};
        for (int m = 0; m < 4; m++) begin
            MODE = modes[m];
            pulse_clr();
            for (int t = 0; t < 3; t++) begin
                SW_IN[2] = 1'b1;
                tick(8);
                if (modes[m] == 2'b00) begin
                    checks++;
                    if (SW_STATE[2] !== 1'b1) begin
                        failures++;
                        $display("FAIL mode00_tracks: state2=%b want 1", SW_STATE[2]);
                    end
                end
                SW_IN[2] = 1'b0;
                tick(8);
            end
            checks++;
            if (qch(2) !== expq[m]) begin
                failures++;
                $display("FAIL mode_%b_count: q2=%0d want %0d", modes[m], qch(2), expq[m]);
            end
        end
        MODE = 2'b01;
    endtask

    task automatic test_wrap();
        pulse_clr();
        for (int r = 0; r < 9; r++) toggle(3);
        checks++;
        if (qch(3) !== 4'd9) begin
            failures++;
            $display("FAIL wrap_nine: q3=%0d want 9", qch(3));
        end
        SW_IN[3] = 1'b1;
        tick(5);
        checks++;
        if (qch(3) !== 4'd9 || CARRY !== 4'b0000) begin
            failures++;
            $display("FAIL wrap_pre: q3=%0d carry=%b want 9/0000", qch(3), CARRY);
        end
        tick(1);
        checks++;
        if (qch(3) !== 4'd0 || CARRY !== 4'b1000 || EDGE !== 4'b1000) begin
            failures++;
            $display("FAIL wrap_carry: q3=%0d carry=%b edge=%b want 0/1000/1000",
                     qch(3), CARRY, EDGE);
        end
        tick(1);
        checks++;
        if (CARRY !== 4'b0000 || EDGE !== 4'b0000 || qch(3) !== 4'd0) begin
            failures++;
            $display("FAIL wrap_carry_once: carry=%b edge=%b q3=%0d want 0000/0000/0",
                     CARRY, EDGE, qch(3));
        end
        SW_IN[3] = 1'b0;
        tick(8);
    endtask

    task automatic test_clr_collision();
        SW_IN[0] = 1'b0;
        tick(8);
        pulse_clr();
        for (int r = 0; r < 9; r++) toggle(0);
        checks++;
        if (qch(0) !== 4'd9) begin
            failures++;
            $display("FAIL clr_setup: q0=%0d want 9", qch(0));
        end
        SW_IN[0] = 1'b1;
        tick(5);
        CLR = 1'b1;
        tick(1);
        CLR = 1'b0;
        checks++;
        if (qch(0) !== 4'd0 || CARRY[0] !== 1'b0 || EDGE[0] !== 1'b1) begin
            failures++;
            $display("FAIL clr_collision: q0=%0d carry0=%b edge0=%b want 0/0/1",
                     qch(0), CARRY[0], EDGE[0]);
        end
        tick(8);
        SW_IN[0] = 1'b0;
        tick(8);
        SW_IN[0] = 1'b1;
        tick(8);
        checks++;
        if (qch(0) !== 4'd1) begin
            failures++;
            $display("FAIL clr_next_rise: q0=%0d want 1", qch(0));
        end
    endtask

    task automatic test_reset_mid();
        for (int r = 0; r < 4; r++) begin
            SW_IN[0] = 1'b0;
            tick(8);
            SW_IN[0] = 1'b1;
            tick(8);
        end
        checks++;
        if (qch(0) !== 4'd5) begin
            failures++;
            $display("FAIL reset_setup: q0=%0d want 5", qch(0));
        end
        SW_IN[0] = 1'b0;
        tick(3);
        SW_IN[0] = 1'b1;
        RESET_B  = 1'b0;
        #1;
        checks++;
        if ({SW_STATE, EDGE, CARRY, Q} !== 28'h0) begin
            failures++;
            $display("FAIL reset_async: got %h want 0", {SW_STATE, EDGE, CARRY, Q});
        end
        tick(2);
        RESET_B = 1'b1;
        tick(5);
        checks++;
        if (qch(0) !== 4'd0 || SW_STATE !== 4'b0000) begin
            failures++;
            $display("FAIL reset_release_early: q0=%0d state=%b want 0/0000", qch(0), SW_STATE);
        end
        tick(1);
        checks++;
        if (qch(0) !== 4'd1 || SW_STATE !== 4'b0001 || EDGE !== 4'b0001) begin
            failures++;
            $display("FAIL reset_release_rise: q0=%0d state=%b edge=%b want 1/0001/0001",
                     qch(0), SW_STATE, EDGE);
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_glitch();
        test_modes();
        test_wrap();
        test_clr_collision();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
